// File: rtl/segment_protection_unit.sv
// segment_protection_unit: per-segment execute/write permission check with a
// byte-wide config bus, sticky lock, scan access and first-fault capture.
// Optional feature macro: SPU_FAULT_COUNTER_EN (saturating fault counter,
// cleared by a config write to address 2*NB+1).
module segment_protection_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned SEG_BITS   = 4,
    parameter logic [(1 << SEG_BITS)-1:0] RESET_EXEC  = 16'h0001,
    parameter logic [(1 << SEG_BITS)-1:0] RESET_WRITE = 16'hFFFE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spu_enable,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  exec_illegal,
    output logic                  wr_illegal,
    input  logic                  cfg_we,
    input  logic [SEG_BITS-2:0]   cfg_addr,
    input  logic [7:0]            cfg_wdata,
    output logic [7:0]            cfg_rdata,
    output logic                  fault_irq,
    output logic [1:0]            fault_cause,
    output logic [ADDR_WIDTH-1:0] fault_addr,
    output logic                  fault_overrun,
    input  logic                  fault_ack,
    output logic [7:0]            fault_count,
    input  logic                  scan_enable,
    input  logic                  scan_in,
    output logic                  scan_out
);

    localparam int unsigned SEG_COUNT = 1 << SEG_BITS;
    localparam int unsigned NB        = SEG_COUNT / 8;
    localparam int unsigned CA_W      = SEG_BITS - 1;

    localparam logic [CA_W-1:0] CTRL_ADDR = CA_W'(2 * NB);
    localparam logic [CA_W-1:0] CNT_ADDR  = CA_W'(2 * NB + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [SEG_COUNT-1:0]  exec_mask;
    logic [SEG_COUNT-1:0]  write_mask;
    logic                  lock;
    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [1:0]            cause_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  overrun_nxt;
    logic [SEG_BITS-1:0]   fetch_seg;
    logic [SEG_BITS-1:0]   wr_seg;
    logic                  any_illegal;

    assign fetch_seg = fetch_addr[ADDR_WIDTH-1 -: SEG_BITS];
    assign wr_seg    = wr_addr[ADDR_WIDTH-1 -: SEG_BITS];

    // Illegal-access detection against the current (pre-write) masks
    assign exec_illegal = fetch_valid & spu_enable & ~scan_enable & ~exec_mask[fetch_seg];
    assign wr_illegal   = wr_valid & spu_enable & ~scan_enable & ~write_mask[wr_seg];
    assign any_illegal  = exec_illegal | wr_illegal;

    assign scan_out  = exec_mask[0];
    assign fault_irq = (state == PEND);

    // Mask and lock storage: scan shift, or config writes gated by lock
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_mask  <= RESET_EXEC;
            write_mask <= RESET_WRITE;
            lock       <= 1'b0;
        end else if (scan_enable) begin
            {lock, write_mask, exec_mask} <= {scan_in, lock, write_mask, exec_mask[SEG_COUNT-1:1]};
        end else if (cfg_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (!lock && cfg_addr == CA_W'(b)) begin
                    exec_mask[8*b +: 8] <= cfg_wdata;
                end
                if (!lock && cfg_addr == CA_W'(NB + b)) begin
                    write_mask[8*b +: 8] <= cfg_wdata;
                end
            end
            if (cfg_addr == CTRL_ADDR && cfg_wdata[0]) begin
                lock <= 1'b1;
            end
        end
    end

    // Config read-back mux
    always_comb begin
        cfg_rdata = 8'h00;
        for (int unsigned b = 0; b < NB; b++) begin
            if (cfg_addr == CA_W'(b)) begin
                cfg_rdata = exec_mask[8*b +: 8];
            end
            if (cfg_addr == CA_W'(NB + b)) begin
                cfg_rdata = write_mask[8*b +: 8];
            end
        end
        if (cfg_addr == CTRL_ADDR) begin
            cfg_rdata = {7'h00, lock};
        end
`ifdef SPU_FAULT_COUNTER_EN
        if (cfg_addr == CNT_ADDR) begin
            cfg_rdata = fault_count;
        end
`endif
    end

    // Fault FSM state register and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fault_cause   <= 2'b00;
            fault_addr    <= '0;
            fault_overrun <= 1'b0;
        end else begin
            state         <= state_nxt;
            fault_cause   <= cause_nxt;
            fault_addr    <= addr_nxt;
            fault_overrun <= overrun_nxt;
        end
    end

    // Fault FSM next state: first fault captured, later ones flag overrun
    always_comb begin
        state_nxt   = state;
        cause_nxt   = fault_cause;
        addr_nxt    = fault_addr;
        overrun_nxt = fault_overrun;
        if (!scan_enable) begin
            case (state)
                IDLE: begin
                    if (any_illegal) begin
                        state_nxt   = PEND;
                        cause_nxt   = {wr_illegal, exec_illegal};
                        addr_nxt    = exec_illegal ? fetch_addr : wr_addr;
                        overrun_nxt = 1'b0;
                    end
                end
                PEND: begin
                    if (fault_ack) begin
                        if (any_illegal) begin
                            state_nxt   = PEND;
                            cause_nxt   = {wr_illegal, exec_illegal};
                            addr_nxt    = exec_illegal ? fetch_addr : wr_addr;
                            overrun_nxt = 1'b0;
                        end else begin
                            state_nxt   = IDLE;
                            cause_nxt   = 2'b00;
                            addr_nxt    = '0;
                            overrun_nxt = 1'b0;
                        end
                    end else if (any_illegal) begin
                        overrun_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef SPU_FAULT_COUNTER_EN
    // Saturating count of cycles with at least one illegal access
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count <= 8'h00;
        end else if (!scan_enable) begin
            if (cfg_we && cfg_addr == CNT_ADDR) begin
                fault_count <= 8'h00;
            end else if (any_illegal && fault_count != 8'hFF) begin
                fault_count <= fault_count + 8'h01;
            end
        end
    end
`else
    assign fault_count = 8'h00;
`endif

endmodule

// File: tb/tb_segment_protection_unit.sv
// tb_segment_protection_unit: directed tests for segment_protection_unit
// with the default 8-bit address / 16-segment configuration.
module tb_segment_protection_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       spu_enable;
    logic       fetch_valid;
    logic [7:0] fetch_addr;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic       exec_illegal;
    logic       wr_illegal;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       fault_irq;
    logic [1:0] fault_cause;
    logic [7:0] fault_addr;
    logic       fault_overrun;
    logic       fault_ack;
    logic [7:0] fault_count;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;

    int checks = 0;
    int errors = 0;

    segment_protection_unit dut (
        .clk(clk), .rst(rst), .spu_enable(spu_enable),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr),
        .exec_illegal(exec_illegal), .wr_illegal(wr_illegal),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .fault_irq(fault_irq), .fault_cause(fault_cause), .fault_addr(fault_addr),
        .fault_overrun(fault_overrun), .fault_ack(fault_ack), .fault_count(fault_count),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid = 1'b0; fetch_addr = 8'h00;
        wr_valid = 1'b0;    wr_addr = 8'h00;
        cfg_we = 1'b0;      cfg_addr = 3'd0; cfg_wdata = 8'h00;
        fault_ack = 1'b0;   scan_enable = 1'b0; scan_in = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        spu_enable = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_rd [0:6];
        exp_rd = '{8'h01, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00};
        do_reset();
        checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", fault_irq); end
        checks++; if (fault_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b exp 00", fault_cause); end
        checks++; if (fault_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", fault_addr); end
        checks++; if (fault_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", fault_overrun); end
        checks++; if (fault_count !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", fault_count); end
        checks++; if (scan_out !== 1'b1) begin errors++; $display("FAIL reset_scan_out got %b exp 1", scan_out); end
        for (int a = 0; a < 7; a++) begin
            cfg_addr = 3'(a);
            #1;
            checks++;
            if (cfg_rdata !== exp_rd[a]) begin errors++; $display("FAIL reset_rd%0d got %h exp %h", a, cfg_rdata, exp_rd[a]); end
        end
    endtask

    task automatic test_exec_fault();
        fetch_valid = 1'b1; fetch_addr = 8'h05;
        #1;
        checks++; if (exec_illegal !== 1'b0) begin errors++; $display("FAIL exec_legal got %b exp 0", exec_illegal); end
        step();
        checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL exec_legal_irq got %b exp 0", fault_irq); end
        fetch_addr = 8'h15;
        #1;
        checks++; if (exec_illegal !== 1'b1) begin errors++; $display("FAIL exec_illegal got %b exp 1", exec_illegal); end
        step();
        fetch_valid = 1'b0;
        checks++; if (fault_irq !== 1'b1) begin errors++; $display("FAIL exec_irq got %b exp 1", fault_irq); end
        checks++; if (fault_cause !== 2'b01) begin errors++; $display("FAIL exec_cause got %b exp 01", fault_cause); end
        checks++; if (fault_addr !== 8'h15) begin errors++; $display("FAIL exec_addr got %h exp 15", fault_addr); end
    endtask

    task automatic test_overrun();
        wr_valid = 1'b1; wr_addr = 8'h03;
        #1;
        checks++; if (wr_illegal !== 1'b1) begin errors++; $display("FAIL ovr_wr_illegal got %b exp 1", wr_illegal); end
        step();
        wr_valid = 1'b0;
        checks++; if (fault_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", fault_overrun); end
        checks++; if (fault_addr !== 8'h15) begin errors++; $display("FAIL ovr_addr got %h exp 15", fault_addr); end
        checks++; if (fault_cause !== 2'b01) begin errors++; $display("FAIL ovr_cause got %b exp 01", fault_cause); end
        fault_ack = 1'b1;
        step();
        checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL ack_irq got %b exp 0", fault_irq); end
        checks++; if (fault_cause !== 2'b00) begin errors++; $display("FAIL ack_cause got %b exp 00", fault_cause); end
        checks++; if (fault_addr !== 8'h00) begin errors++; $display("FAIL ack_addr got %h exp 00", fault_addr); end
        checks++; if (fault_overrun !== 1'b0) begin errors++; $display("FAIL ack_overrun got %b exp 0", fault_overrun); end
        step();
        fault_ack = 1'b0;
        checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL idle_ack_irq got %b exp 0", fault_irq); end
    endtask

    task automatic test_enable();
        spu_enable = 1'b0;
        fetch_valid = 1'b1; fetch_addr = 8'h15;
        wr_valid = 1'b1;    wr_addr = 8'h03;
        #1;
        checks++; if (exec_illegal !== 1'b0) begin errors++; $display("FAIL dis_exec got %b exp 0", exec_illegal); end
        checks++; if (wr_illegal !== 1'b0) begin errors++; $display("FAIL dis_wr got %b exp 0", wr_illegal); end
        step();
        fetch_valid = 1'b0; wr_valid = 1'b0;
        checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL dis_irq got %b exp 0", fault_irq); end
        spu_enable = 1'b1;
    endtask

    task automatic test_lock();
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 8'h80;
        fetch_valid = 1'b1; fetch_addr = 8'hF0;
        #1;
        checks++; if (exec_illegal !== 1'b1) begin errors++; $display("FAIL prewrite_exec got %b exp 1", exec_illegal); end
        step();
        cfg_we = 1'b0;
        #1;
        checks++; if (exec_illegal !== 1'b0) begin errors++; $display("FAIL postwrite_exec got %b exp 0", exec_illegal); end
        fetch_valid = 1'b0;
        checks++; if (fault_addr !== 8'hF0) begin errors++; $display("FAIL prewrite_addr got %h exp F0", fault_addr); end
        fault_ack = 1'b1;
        step();
        fault_ack = 1'b0;
        cfg_write(3'd4, 8'h01);
        cfg_write(3'd1, 8'h00);
        cfg_addr = 3'd1;
        #1;
        checks++; if (cfg_rdata !== 8'h80) begin errors++; $display("FAIL lock_rd1 got %h exp 80", cfg_rdata); end
        cfg_addr = 3'd4;
        #1;
        checks++; if (cfg_rdata !== 8'h01) begin errors++; $display("FAIL lock_ctrl got %h exp 01", cfg_rdata); end
        fetch_valid = 1'b1; fetch_addr = 8'hF0;
        #1;
        checks++; if (exec_illegal !== 1'b0) begin errors++; $display("FAIL lock_exec got %b exp 0", exec_illegal); end
        step();
        fetch_valid = 1'b0;
        checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL lock_irq got %b exp 0", fault_irq); end
    endtask

    task automatic test_ack_new_fault();
        do_reset();
        fetch_valid = 1'b1; fetch_addr = 8'h25;
        step();
        fetch_addr = 8'h35;
        step();
        fetch_valid = 1'b0;
        checks++; if (fault_overrun !== 1'b1) begin errors++; $display("FAIL acknew_pre_ovr got %b exp 1", fault_overrun); end
        fault_ack = 1'b1; wr_valid = 1'b1; wr_addr = 8'h0A;
        step();
        fault_ack = 1'b0; wr_valid = 1'b0;
        checks++; if (fault_irq !== 1'b1) begin errors++; $display("FAIL acknew_irq got %b exp 1", fault_irq); end
        checks++; if (fault_cause !== 2'b10) begin errors++; $display("FAIL acknew_cause got %b exp 10", fault_cause); end
        checks++; if (fault_addr !== 8'h0A) begin errors++; $display("FAIL acknew_addr got %h exp 0A", fault_addr); end
        checks++; if (fault_overrun !== 1'b0) begin errors++; $display("FAIL acknew_ovr got %b exp 0", fault_overrun); end
        fault_ack = 1'b1;
        step();
        fault_ack = 1'b0;
        fetch_valid = 1'b1; fetch_addr = 8'h15;
        wr_valid = 1'b1;    wr_addr = 8'h03;
        step();
        fetch_valid = 1'b0; wr_valid = 1'b0;
        checks++; if (fault_cause !== 2'b11) begin errors++; $display("FAIL both_cause got %b exp 11", fault_cause); end
        checks++; if (fault_addr !== 8'h15) begin errors++; $display("FAIL both_addr got %h exp 15", fault_addr); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL rstpend_irq got %b exp 0", fault_irq); end
        checks++; if (fault_cause !== 2'b00) begin errors++; $display("FAIL rstpend_cause got %b exp 00", fault_cause); end
    endtask

    task automatic test_scan();
        logic [32:0] pat;
        logic [32:0] old_chain;
        logic [32:0] obs;
        logic [7:0]  exp_rd [0:4];
        pat       = {1'b1, 16'h0F0F, 16'hA5C3};
        old_chain = {1'b0, 16'hFFFE, 16'h0001};
        exp_rd    = '{8'hC3, 8'hA5, 8'h0F, 8'h0F, 8'h01};
        obs       = '0;
        do_reset();
        fetch_valid = 1'b1; fetch_addr = 8'h15;
        step();
        fetch_addr = 8'h35; fault_ack = 1'b1;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h00;
        scan_enable = 1'b1;
        for (int k = 0; k < 33; k++) begin
            scan_in = pat[k];
            #1;
            obs[k] = scan_out;
            if (k == 0) begin
                checks++;
                if (exec_illegal !== 1'b0) begin errors++; $display("FAIL scan_exec got %b exp 0", exec_illegal); end
            end
            if (k == 32) begin
                fetch_valid = 1'b0; fault_ack = 1'b0; cfg_we = 1'b0;
            end
            step();
        end
        scan_enable = 1'b0;
        checks++; if (obs !== old_chain) begin errors++; $display("FAIL scan_out got %h exp %h", obs, old_chain); end
        checks++; if (fault_irq !== 1'b1) begin errors++; $display("FAIL scan_irq got %b exp 1", fault_irq); end
        checks++; if (fault_cause !== 2'b01) begin errors++; $display("FAIL scan_cause got %b exp 01", fault_cause); end
        checks++; if (fault_addr !== 8'h15) begin errors++; $display("FAIL scan_addr got %h exp 15", fault_addr); end
        checks++; if (fault_overrun !== 1'b0) begin errors++; $display("FAIL scan_ovr got %b exp 0", fault_overrun); end
        for (int a = 0; a < 5; a++) begin
            cfg_addr = 3'(a);
            #1;
            checks++;
            if (cfg_rdata !== exp_rd[a]) begin errors++; $display("FAIL scan_rd%0d got %h exp %h", a, cfg_rdata, exp_rd[a]); end
        end
        cfg_write(3'd0, 8'hFF);
        cfg_addr = 3'd0;
        #1;
        checks++; if (cfg_rdata !== 8'hC3) begin errors++; $display("FAIL scan_lock got %h exp C3", cfg_rdata); end
    endtask

    task automatic test_counter();
        do_reset();
        fetch_valid = 1'b1; fetch_addr = 8'h15;
        wr_valid = 1'b1;    wr_addr = 8'h03;
        repeat (3) step();
`ifdef SPU_FAULT_COUNTER_EN
        checks++; if (fault_count !== 8'h03) begin errors++; $display("FAIL cnt_3 got %h exp 03", fault_count); end
        repeat (297) step();
        fetch_valid = 1'b0; wr_valid = 1'b0;
        checks++; if (fault_count !== 8'hFF) begin errors++; $display("FAIL cnt_sat got %h exp FF", fault_count); end
        cfg_addr = 3'd5;
        #1;
        checks++; if (cfg_rdata !== 8'hFF) begin errors++; $display("FAIL cnt_rd got %h exp FF", cfg_rdata); end
        cfg_write(3'd5, 8'h5A);
        checks++; if (fault_count !== 8'h00) begin errors++; $display("FAIL cnt_clr got %h exp 00", fault_count); end
`else
        fetch_valid = 1'b0; wr_valid = 1'b0;
        checks++; if (fault_count !== 8'h00) begin errors++; $display("FAIL cnt_tied got %h exp 00", fault_count); end
        cfg_addr = 3'd5;
        #1;
        checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL cnt_rd got %h exp 00", cfg_rdata); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        spu_enable = 1'b1;
        idle_inputs();
        test_reset();
        test_exec_fault();
        test_overrun();
        test_enable();
        test_lock();
        test_ack_new_fault();
        test_scan();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
